// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner for the EX stage: sequences MULT/MULTU (fixed latency) and DIV/DIVU
// (32-step restoring divider), stalling the pipeline until the result is committed.
module muldiv_hilo_ctrl #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_flush,
    input  logic        i_is_mult,
    input  logic        i_is_multu,
    input  logic        i_is_div,
    input  logic        i_is_divu,
    input  logic        i_hi_wen,
    input  logic        i_lo_wen,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic        o_stall,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LAST = 6'd33;
    localparam bit         MUL_COMB = (MUL_CYCLES == 1);

    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic        r_signed;
    logic [31:0] r_opa;      // multiplicand, or dividend shifting into quotient
    logic [31:0] r_opb;      // multiplier, or divisor magnitude
    logic [31:0] r_rem;
    logic        r_q_neg, r_r_neg;
    logic [63:0] r_prod;
    logic [31:0] r_hi, r_lo;

    logic        w_req_any, w_start, w_div_req, w_signed;
    logic        w_mul_last, w_div_last;
    logic [31:0] w_rs_mag, w_rt_mag;
    logic [63:0] w_ext_a, w_ext_b, w_prod, w_mul_res;
    logic [32:0] w_rem_sh, w_sub;
    logic        w_qbit;
    logic [31:0] w_rem_next, w_quot_fix, w_rem_fix;

    assign w_req_any = i_is_mult | i_is_multu | i_is_div | i_is_divu;
    assign w_start   = i_valid & ~i_flush & (r_state == S_IDLE) & w_req_any;
    // Priority div > divu > mult > multu decides both the unit and the signedness.
    assign w_div_req = i_is_div | i_is_divu;
    assign w_signed  = i_is_div | (~i_is_divu & i_is_mult);

    assign w_mul_last = (r_state == S_MUL) && (r_cnt == MUL_LAST);
    assign w_div_last = (r_state == S_DIV) && (r_cnt == DIV_LAST);

    assign w_rs_mag = (w_signed & i_rs_data[31]) ? -i_rs_data : i_rs_data;
    assign w_rt_mag = (w_signed & i_rt_data[31]) ? -i_rt_data : i_rt_data;

    // Sign-extending to 64 bits lets one unsigned multiplier serve both modes.
    assign w_ext_a   = {{32{r_signed & r_opa[31]}}, r_opa};
    assign w_ext_b   = {{32{r_signed & r_opb[31]}}, r_opb};
    assign w_prod    = w_ext_a * w_ext_b;
    assign w_mul_res = MUL_COMB ? w_prod : r_prod;

    // 33-bit partial remainder so divisors with bit 31 set divide correctly.
    assign w_rem_sh   = {r_rem, r_opa[31]};
    assign w_qbit     = (w_rem_sh >= {1'b0, r_opb});
    assign w_sub      = w_rem_sh - {1'b0, r_opb};
    assign w_rem_next = w_qbit ? w_sub[31:0] : w_rem_sh[31:0];

    assign w_quot_fix = r_q_neg ? -r_opa : r_opa;
    assign w_rem_fix  = r_r_neg ? -r_rem : r_rem;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // NOTE: a default assignment first keeps every comb path fully assigned, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_next = w_div_req ? S_DIV : S_MUL;
                S_MUL:   if (w_mul_last) w_next = S_IDLE;
                S_DIV:   if (w_div_last) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_stall = 1'b0;
        if (!i_reset) begin
            case (r_state)
                S_IDLE:  o_stall = w_start;
                S_MUL:   o_stall = ~i_flush & ~w_mul_last;
                S_DIV:   o_stall = ~i_flush & ~w_div_last;
                default: o_stall = 1'b0;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the datapath registers are reset as well, keeping simulation free of X after reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_prod   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt <= 6'd1;
                        if (w_div_req) begin
                            r_opa   <= w_rs_mag;
                            r_opb   <= w_rt_mag;
                            r_rem   <= '0;
                            r_q_neg <= w_signed & (i_rs_data[31] ^ i_rt_data[31]);
                            r_r_neg <= w_signed & i_rs_data[31];
                        end else begin
                            r_opa    <= i_rs_data;
                            r_opb    <= i_rt_data;
                            r_signed <= w_signed;
                        end
                    end else if (i_valid && !i_flush) begin
                        if (i_hi_wen) r_hi <= i_rs_data;
                        if (i_lo_wen) r_lo <= i_rs_data;
                    end
                end
                S_MUL: begin
                    if (i_flush || w_mul_last) begin
                        r_cnt <= '0;
                        if (!i_flush) {r_hi, r_lo} <= w_mul_res;
                    end else begin
                        r_cnt  <= r_cnt + 6'd1;
                        r_prod <= w_prod;
                    end
                end
                S_DIV: begin
                    if (i_flush || w_div_last) begin
                        r_cnt <= '0;
                        if (!i_flush) begin
                            r_lo <= w_quot_fix;
                            r_hi <= w_rem_fix;
                        end
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        r_opa <= {r_opa[30:0], w_qbit};
                        r_rem <= w_rem_next;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: hand-computed MUL/DIV results, stall lengths,
// flush abort, MTHI/MTLO and asynchronous reset mid-operation.
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset, valid, flush;
    logic        is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen;
    logic [31:0] rs_data, rt_data;
    logic        stall, busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_hilo_ctrl #(.MUL_CYCLES(3)) dut (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_flush(flush),
        .i_is_mult(is_mult), .i_is_multu(is_multu), .i_is_div(is_div), .i_is_divu(is_divu),
        .i_hi_wen(hi_wen), .i_lo_wen(lo_wen), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .o_stall(stall), .o_busy(busy), .o_hi(hi), .o_lo(lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        valid = 0; flush = 0; is_mult = 0; is_multu = 0; is_div = 0; is_divu = 0;
        hi_wen = 0; lo_wen = 0; rs_data = '0; rt_data = '0;
    endtask

    // req = {div, divu, mult, multu}; counts stall-high cycles, then checks the commit.
    task automatic do_op(input string tag, input logic [3:0] req, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        @(negedge clk);
        valid = 1; {is_div, is_divu, is_mult, is_multu} = req;
        rs_data = a; rt_data = b;
        #1;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        @(negedge clk);
        idle_inputs();
        #1;
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        valid = 1; is_mult = 1;
        #1;
        check("rst_stall_forced", {31'b0, stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 0;

        do_op("mult_neg2x3",   4'b0010, 32'hFFFFFFFE, 32'd3,          3,  32'hFFFFFFFF, 32'hFFFFFFFA);
        do_op("multu_max",     4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF,   3,  32'hFFFFFFFE, 32'h00000001);
        do_op("div_m7_2",      4'b1000, 32'hFFFFFFF9, 32'd2,          33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_7_m2",      4'b1000, 32'd7,        32'hFFFFFFFE,   33, 32'h00000001, 32'hFFFFFFFD);
        do_op("divu_100_0",    4'b0100, 32'd100,      32'd0,          33, 32'd100,      32'hFFFFFFFF);
        do_op("divu_max_16",   4'b0100, 32'hFFFFFFFF, 32'h10,         33, 32'hF,        32'h0FFFFFFF);
        do_op("div_min_m1",    4'b1000, 32'h80000000, 32'hFFFFFFFF,   33, 32'h0,        32'h80000000);
        do_op("divu_big_dvs",  4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFE,   33, 32'h1,        32'h1);
        do_op("prio_div_mult", 4'b1010, 32'd20,       32'd6,          33, 32'd2,        32'd3);

        // DIV aborted by flush at cycle 10: hi/lo keep 2/3 from the previous op.
        @(negedge clk);
        valid = 1; is_div = 1; rs_data = 32'd1000; rt_data = 32'd3;
        #1;
        check("flush_c0_stall", {31'b0, stall}, 32'd1);
        repeat (10) @(negedge clk);
        flush = 1;
        #1;
        check("flush_c10_stall", {31'b0, stall}, 32'd0);
        check("flush_c10_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("flush_busy_next", {31'b0, busy}, 32'd0);
        check("flush_hi_kept", hi, 32'd2);
        check("flush_lo_kept", lo, 32'd3);

        do_op("div_after_flush", 4'b1000, 32'd100, 32'd9, 33, 32'd1, 32'd11);

        // Flush in the same cycle as a request: no start.
        @(negedge clk);
        valid = 1; is_mult = 1; flush = 1; rs_data = 32'd5; rt_data = 32'd5;
        #1;
        check("flush_vs_start_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("flush_vs_start_busy", {31'b0, busy}, 32'd0);
        check("flush_vs_start_lo", lo, 32'd11);

        // MTLO then MTHI back to back.
        @(negedge clk);
        valid = 1; lo_wen = 1; rs_data = 32'h1234;
        #1;
        check("mtlo_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        lo_wen = 0; hi_wen = 1; rs_data = 32'h5678;
        #1;
        check("mtlo_visible", lo, 32'h1234);
        check("mthi_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mthi_hi", hi, 32'h5678);
        check("mthi_lo", lo, 32'h1234);

        // Asynchronous reset mid-DIV.
        @(negedge clk);
        valid = 1; is_div = 1; rs_data = 32'd77; rt_data = 32'd5;
        repeat (5) @(negedge clk);
        #1;
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        reset = 1;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
